tc_sram_rr_arbiter: RTL

Shares one port of a single-port, fixed-latency SRAM macro among NumReq requesters using round-robin arbitration with a req/gnt handshake. Tracks every granted read through a Latency-deep tag pipeline and returns the data with a per-requester rvalid. An optional post-reset sequencer zero-fills the whole array before any requester is served. Sits between core/DMA request ports and the SRAM macro instance.

---
 rtl/tc_sram_rr_arbiter.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/tc_sram_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tc_sram_rr_arbiter
// Purpose  : Round-robin arbiter sharing one port of a single-port,
//            fixed-latency SRAM macro among NumReq requesters. A granted read
//            is tracked through a Latency-deep tag pipeline so the returning
//            data is flagged with a per-requester rvalid. An optional
//            post-reset sequencer zero-fills the array before any requester
//            is served.
// Ports    : clk_i, rst_ni (async, active-low)
//            req_i/we_i/addr_i/wdata_i/be_i : per-requester request bundle
//            gnt_o        : one-hot (or zero) grant, combinational
//            rvalid_o     : per-requester read-data valid
//            rdata_o      : shared read data (SRAM rdata passed through)
//            init_done_o  : array is usable (RUN state)
//            sram_*_o / sram_rdata_i : SRAM macro port
// Revision : 1.0 - initial release
// ============================================================================
module tc_sram_rr_arbiter #(
  parameter int unsigned NumReq      = 4,
  parameter int unsigned NumWords    = 1024,
  parameter int unsigned DataWidth   = 32,
  parameter int unsigned ByteWidth   = 8,
  parameter int unsigned Latency     = 1,
  parameter int unsigned InitOnReset = 1,
  localparam int unsigned AddrWidth  = (NumWords > 1) ? $clog2(NumWords) : 1,
  localparam int unsigned BeWidth    = (DataWidth + ByteWidth - 1) / ByteWidth
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic [NumReq-1:0]                   req_i,
  input  logic [NumReq-1:0]                   we_i,
  input  logic [NumReq-1:0][AddrWidth-1:0]    addr_i,
  input  logic [NumReq-1:0][DataWidth-1:0]    wdata_i,
  input  logic [NumReq-1:0][BeWidth-1:0]      be_i,
  output logic [NumReq-1:0]                   gnt_o,
  output logic [NumReq-1:0]                   rvalid_o,
  output logic [DataWidth-1:0]                rdata_o,
  output logic                                init_done_o,
  output logic                                sram_req_o,
  output logic                                sram_we_o,
  output logic [AddrWidth-1:0]                sram_addr_o,
  output logic [DataWidth-1:0]                sram_wdata_o,
  output logic [BeWidth-1:0]                  sram_be_o,
  input  logic [DataWidth-1:0]                sram_rdata_i
);

  localparam int unsigned PTR_W = (NumReq > 1) ? $clog2(NumReq) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_INIT = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  state_e               r_state;
  state_e               w_state_next;
  logic [AddrWidth-1:0] r_init_cnt;
  logic                 w_init_last;
  logic [PTR_W-1:0]     r_ptr;
  logic                 w_arb_valid;
  logic [PTR_W-1:0]     w_arb_idx;
  logic                 w_grant;
  logic                 w_rd_grant;

  // Last values put on the SRAM port; replayed while the port is idle so
  // the macro inputs never float or toggle needlessly.
  logic                 r_hold_we;
  logic [AddrWidth-1:0] r_hold_addr;
  logic [DataWidth-1:0] r_hold_wdata;
  logic [BeWidth-1:0]   r_hold_be;

  // (base + off) mod NumReq, narrowed back to a requester index.
  function automatic logic [PTR_W-1:0] rr_idx(input logic [PTR_W-1:0] base,
                                              input int unsigned   off);
    return PTR_W'((32'(base) + off) % NumReq);
  endfunction

  // --------------------------------------------------------------------------
  // State machine
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  assign w_init_last = (r_init_cnt == AddrWidth'(NumWords - 1));

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: w_state_next = (InitOnReset != 0) ? ST_INIT : ST_RUN;
      ST_INIT: if (w_init_last) w_state_next = ST_RUN;
      ST_RUN:  w_state_next = ST_RUN;
      default: w_state_next = ST_IDLE;
    endcase
  end

  assign init_done_o = (r_state == ST_RUN);

  // --------------------------------------------------------------------------
  // Round-robin search: first asserted request at or after the pointer.
  // --------------------------------------------------------------------------
  always_comb begin
    w_arb_valid = 1'b0;
    w_arb_idx   = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      if (!w_arb_valid && req_i[rr_idx(r_ptr, i)]) begin
        w_arb_valid = 1'b1;
        w_arb_idx   = rr_idx(r_ptr, i);
      end
    end
  end

  assign w_grant    = (r_state == ST_RUN) && w_arb_valid;
  assign w_rd_grant = w_grant && !we_i[w_arb_idx];

  always_comb begin
    gnt_o = '0;
    if (w_grant) gnt_o[w_arb_idx] = 1'b1;
  end

  // --------------------------------------------------------------------------
  // SRAM port drive
  // --------------------------------------------------------------------------
  always_comb begin
    sram_req_o   = 1'b0;
    sram_we_o    = r_hold_we;
    sram_addr_o  = r_hold_addr;
    sram_wdata_o = r_hold_wdata;
    sram_be_o    = r_hold_be;
    if (r_state == ST_INIT) begin
      sram_req_o   = 1'b1;
      sram_we_o    = 1'b1;
      sram_addr_o  = r_init_cnt;
      sram_wdata_o = '0;
      sram_be_o    = '1;
    end else if (w_grant) begin
      sram_req_o   = 1'b1;
      sram_we_o    = we_i[w_arb_idx];
      sram_addr_o  = addr_i[w_arb_idx];
      sram_wdata_o = wdata_i[w_arb_idx];
      sram_be_o    = be_i[w_arb_idx];
    end
  end

  assign rdata_o = sram_rdata_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_init_cnt   <= '0;
      r_ptr        <= '0;
      r_hold_we    <= 1'b0;
      r_hold_addr  <= '0;
      r_hold_wdata <= '0;
      r_hold_be    <= '0;
    end else begin
      if ((r_state == ST_INIT) && !w_init_last) begin
        r_init_cnt <= r_init_cnt + AddrWidth'(1);
      end
      if (w_grant) begin
        r_ptr <= rr_idx(w_arb_idx, 1);
      end
      if (sram_req_o) begin
        r_hold_we    <= sram_we_o;
        r_hold_addr  <= sram_addr_o;
        r_hold_wdata <= sram_wdata_o;
        r_hold_be    <= sram_be_o;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Read tag pipeline: {valid, requester id} delayed by the macro latency.
  // Reads are granted at most once per cycle, so responses stay in order and
  // at most one rvalid bit is ever set.
  // --------------------------------------------------------------------------
  if (Latency == 0) begin : g_lat0
    always_comb begin
      rvalid_o = '0;
      if (w_rd_grant) rvalid_o[w_arb_idx] = 1'b1;
    end
  end else begin : g_latn
    logic [Latency-1:0] r_tag_vld;
    logic [PTR_W-1:0]   r_tag_id [Latency];

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        r_tag_vld <= '0;
        for (int unsigned i = 0; i < Latency; i++) begin
          r_tag_id[i] <= '0;
        end
      end else begin
        r_tag_vld[0] <= w_rd_grant;
        r_tag_id[0]  <= w_arb_idx;
        for (int unsigned i = 1; i < Latency; i++) begin
          r_tag_vld[i] <= r_tag_vld[i-1];
          r_tag_id[i]  <= r_tag_id[i-1];
        end
      end
    end

    always_comb begin
      rvalid_o = '0;
      if (r_tag_vld[Latency-1]) rvalid_o[r_tag_id[Latency-1]] = 1'b1;
    end
  end

endmodule
`default_nettype wire
